// File: rtl/ebike_pb_pkg.sv
// Shared types for the ebike handlebar push-button front end.
// State encoding of the debounce FSM.
package ebike_pb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REL_WAIT
    } pb_state_t;

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchronizer for asynchronous handlebar inputs.
// RST_VAL sets the level both flops take during reset.
module pb_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/pb_debounce.sv
// Mode push-button debouncer: sync, counter FSM, press pulse.
// Define LONG_PRESS_EN to enable the one-shot long_press output.
module pb_debounce
    import ebike_pb_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 50000,
    parameter int unsigned LONG_CYCLES = 100000000,
    parameter bit          PB_ACT_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic PB_raw,
    output logic tgglMd,
    output logic press_pulse,
    output logic long_press
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

    logic pb_q;
    logic pb_s;

    pb_sync #(
        .RST_VAL (PB_ACT_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (PB_raw),
        .q     (pb_q)
    );

    assign pb_s = PB_ACT_LOW ? ~pb_q : pb_q;

    pb_state_t      state_q, state_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           tggl_q, tggl_d;
    logic           pulse_q, pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
            tggl_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            tggl_q   <= tggl_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        tggl_d   = tggl_q;
        pulse_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                tggl_d = 1'b0;
                if (pb_s) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!pb_s) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                    tggl_d   = 1'b1;
                    pulse_d  = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            PRESSED: begin
                tggl_d = 1'b1;
                if (!pb_s) begin
                    state_d  = REL_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end
            REL_WAIT: begin
                // release bounce returns to PRESSED without a new pulse
                if (pb_s) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                    tggl_d   = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
                tggl_d   = 1'b0;
            end
        endcase
    end

    assign tgglMd      = tggl_q;
    assign press_pulse = pulse_q;

`ifdef LONG_PRESS_EN
    localparam int LPW = $clog2(LONG_CYCLES + 1);
    localparam logic [LPW-1:0] LP_LAST = LPW'(LONG_CYCLES - 1);
    localparam logic [LPW-1:0] LP_PRE  = LPW'(LONG_CYCLES - 2);
    localparam logic [LPW-1:0] LP_ONE  = LPW'(1);

    logic [LPW-1:0] lp_cnt_q, lp_cnt_d;
    logic           long_q, long_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt_q <= '0;
            long_q   <= 1'b0;
        end else begin
            lp_cnt_q <= lp_cnt_d;
            long_q   <= long_d;
        end
    end

    // saturation at LP_LAST keeps it to one pulse per press
    always_comb begin
        lp_cnt_d = lp_cnt_q;
        long_d   = 1'b0;
        if (state_q == PRESSED && lp_cnt_q != LP_LAST) begin
            lp_cnt_d = lp_cnt_q + LP_ONE;
            long_d   = (lp_cnt_q == LP_PRE);
        end
        if (state_q == REL_WAIT && state_d == IDLE) begin
            lp_cnt_d = '0;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_pb_debounce.sv
// Scoreboard bench for pb_debounce (DB_CYCLES=4, LONG_CYCLES=20).
// Stimulus queues expected output events; a monitor pops and compares.
module tb_pb_debounce;

    localparam int EV_RISE  = 0;
    localparam int EV_FALL  = 1;
    localparam int EV_PULSE = 2;
    localparam int EV_LONG  = 3;
    localparam int LAT      = 6;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk;
    logic rst_n;
    logic PB_raw;
    logic tgglMd;
    logic press_pulse;
    logic long_press;

    int   cyc;
    int   checks;
    int   failures;
    logic prev_t;
    ev_t  exp_q[$];

    pb_debounce #(
        .DB_CYCLES   (4),
        .LONG_CYCLES (20),
        .PB_ACT_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PB_raw      (PB_raw),
        .tgglMd      (tgglMd),
        .press_pulse (press_pulse),
        .long_press  (long_press)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            EV_RISE:  return "rise";
            EV_FALL:  return "fall";
            EV_PULSE: return "press_pulse";
            default:  return "long_press";
        endcase
    endfunction

    task automatic push(input int kind, input int at);
        ev_t e;
        e.cyc  = at;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s: got event at cycle %0d, required none",
                     kname(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                failures++;
                $display("FAIL event_%s: got %s at cycle %0d, required %s at cycle %0d",
                         kname(e.kind), kname(kind), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (tgglMd !== 1'b0 || press_pulse !== 1'b0 || long_press !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs: got t=%b p=%b l=%b, required 0 0 0",
                         tgglMd, press_pulse, long_press);
            end
            prev_t = 1'b0;
        end else begin
            if (tgglMd !== prev_t) observe(tgglMd ? EV_RISE : EV_FALL);
            if (press_pulse) observe(EV_PULSE);
            if (long_press) observe(EV_LONG);
            prev_t = tgglMd;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_at_now();
        push(EV_RISE, cyc + LAT);
        push(EV_PULSE, cyc + LAT);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        prev_t   = 1'b0;
        PB_raw   = 1'b1;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;

        // idle: released button, nothing expected
        step(10);

        // clean press and release
        PB_raw = 1'b0;
        press_at_now();
        step(10);
        PB_raw = 1'b1;
        push(EV_FALL, cyc + LAT);
        step(10);

        // press bounce
        for (int i = 0; i < 5; i++) begin
            PB_raw = 1'b0;
            step(3);
            PB_raw = 1'b1;
            step(1);
        end
        PB_raw = 1'b0;
        press_at_now();
        step(10);

        // release bounce: no extra pulse
        for (int i = 0; i < 5; i++) begin
            PB_raw = 1'b1;
            step(3);
            PB_raw = 1'b0;
            step(1);
        end
        PB_raw = 1'b1;
        push(EV_FALL, cyc + LAT);
        step(10);

        // long hold
        PB_raw = 1'b0;
        press_at_now();
`ifdef LONG_PRESS_EN
        push(EV_LONG, cyc + LAT + 19);
`endif
        step(40);
        PB_raw = 1'b1;
        push(EV_FALL, cyc + LAT);
        step(10);

        // reset during PRESS_WAIT with button still held
        PB_raw = 1'b0;
        step(3);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        press_at_now();
        step(10);
        PB_raw = 1'b1;
        push(EV_FALL, cyc + LAT);
        step(10);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events: got %0d left unseen, required 0",
                     exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
